// File: rtl/vga_pkg.sv
// Shared VGA-path types: blitter state encoding and frame index map.
// The frame constants are shared with the game FSM and the top-level ROM mux.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } blit_state_e;

  localparam int START    = 0;
  localparam int GAME     = 1;
  localparam int MOLE1    = 2;
  localparam int MOLE2    = 3;
  localparam int MOLE3    = 4;
  localparam int MOLE4    = 5;
  localparam int GAMEOVER = 6;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_blitter_raster_counter.sv
// Raster walker: x/y coordinates plus the matching linear address, row-major.
// clear has priority over enable; the final pixel wraps everything back to 0.
module raster_counter
  import vga_pkg::*;
#(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  localparam int X_W    = bits_for(WIDTH),
  localparam int Y_W    = bits_for(HEIGHT),
  localparam int ADDR_W = bits_for(WIDTH * HEIGHT)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              enable_i,
  output logic [X_W-1:0]    x_o,
  output logic [Y_W-1:0]    y_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last;

  assign last = (addr_q == ADDR_W'(WIDTH * HEIGHT - 1));

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clear_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (enable_i) begin
      if (last) begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        if (x_q == X_W'(WIDTH - 1)) begin
          x_d = '0;
          y_d = y_q + Y_W'(1);
        end else begin
          x_d = x_q + X_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign addr_o = addr_q;
  assign last_o = last;

endmodule

// File: rtl/frame_blitter.sv
// Full-screen blitter: sweeps the raster into a frame ROM and realigns colour with coordinates.
// Coordinates ride a ROM_LATENCY-deep register pipe; colour is taken from the ROM in the plot cycle.
module frame_blitter
  import vga_pkg::*;
#(
  parameter int WIDTH           = 160,
  parameter int HEIGHT          = 120,
  parameter int COLOUR_W        = 3,
  parameter int NUM_FRAMES      = 7,
  parameter int ROM_LATENCY     = 1,
  parameter int AUTO_REDRAW     = 1,
  parameter int TRANSPARENT_EN  = 0,
  parameter int TRANSPARENT_KEY = 0,
  localparam int X_W     = bits_for(WIDTH),
  localparam int Y_W     = bits_for(HEIGHT),
  localparam int ADDR_W  = bits_for(WIDTH * HEIGHT),
  localparam int FRAME_W = bits_for(NUM_FRAMES)
) (
  input  logic                iClock,
  input  logic                iResetn,
  input  logic                iStart,
  input  logic [FRAME_W-1:0]  iFrame,
  input  logic [COLOUR_W-1:0] iColour,
  output logic [ADDR_W-1:0]   oAddress,
  output logic [FRAME_W-1:0]  oFrame,
  output logic [X_W-1:0]      oX,
  output logic [Y_W-1:0]      oY,
  output logic [COLOUR_W-1:0] oColour,
  output logic                oPlot,
  output logic                oBusy,
  output logic                oDone
);

  localparam int DRAIN_W = bits_for(ROM_LATENCY + 1);

  typedef struct packed {
    logic           vld;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           last;
  } pix_t;

  blit_state_e          state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 cnt_clr, cnt_en, cnt_last;
  logic [X_W-1:0]       cnt_x;
  logic [Y_W-1:0]       cnt_y;
  logic [ADDR_W-1:0]    cnt_addr;
  logic                 frame_chg, abort, key_hit, plot;
  pix_t                 head, tail;
  pix_t                 pipe_q [ROM_LATENCY];
  logic [X_W-1:0]       x_q;
  logic [Y_W-1:0]       y_q;
  logic [COLOUR_W-1:0]  col_q;

  raster_counter #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_raster (
    .clk_i    (iClock),
    .rst_ni   (iResetn),
    .clear_i  (cnt_clr),
    .enable_i (cnt_en),
    .x_o      (cnt_x),
    .y_o      (cnt_y),
    .addr_o   (cnt_addr),
    .last_o   (cnt_last)
  );

  assign frame_chg = (iFrame != frame_q);
  assign abort     = (state_q != IDLE) && frame_chg;

  // A frame change while busy restarts from address 0 with no dead cycle.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    drain_d = drain_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    if (abort) begin
      state_d = SWEEP;
      frame_d = iFrame;
      drain_d = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_clr = 1'b1;
          if (iStart || ((AUTO_REDRAW != 0) && frame_chg)) begin
            state_d = SWEEP;
            frame_d = iFrame;
          end
        end
        SWEEP: begin
          cnt_en = 1'b1;
          if (cnt_last) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_W'(ROM_LATENCY - 1)) begin
            state_d = IDLE;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q <= IDLE;
      frame_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    head      = '0;
    head.vld  = (state_q == SWEEP);
    head.x    = cnt_x;
    head.y    = cnt_y;
    head.last = cnt_last;
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
    end else if (abort) begin
      for (int i = 0; i < ROM_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= head;
      for (int i = 1; i < ROM_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail    = pipe_q[ROM_LATENCY-1];
  assign key_hit = (TRANSPARENT_EN != 0) && (iColour == COLOUR_W'(TRANSPARENT_KEY));
  // An aborting cycle plots nothing, so the old frame's tail never leaks out.
  assign plot    = tail.vld && !abort && !key_hit;

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      x_q   <= '0;
      y_q   <= '0;
      col_q <= '0;
    end else if (plot) begin
      x_q   <= tail.x;
      y_q   <= tail.y;
      col_q <= iColour;
    end
  end

  assign oAddress = cnt_addr;
  assign oFrame   = frame_q;
  assign oX       = plot ? tail.x  : x_q;
  assign oY       = plot ? tail.y  : y_q;
  assign oColour  = plot ? iColour : col_q;
  assign oPlot    = plot;
  assign oBusy    = (state_q != IDLE);
  assign oDone    = tail.vld && tail.last && !abort;

endmodule
